fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: data width; SHALL equal the memory sub-module data width.
REQ-002 SHALL have parameter AW, default 4: RAM address width; RAM depth is 2**AW = 16.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: synchronous clear of all stored data.
REQ-006 SHALL have port in_valid, input, 1: the producer offers in_data.
REQ-007 SHALL have port in_data, input, DW: write data.
REQ-008 SHALL have port in_ready, output, 1: the block accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1: out_data holds the oldest entry.
REQ-010 SHALL have port out_data, output, DW: read data, driven directly from the RAM read register.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes out_data this cycle.
REQ-012 SHALL have port level, output, AW+1: total entries held, range 0..17.

Function
REQ-013 Push SHALL occur when in_valid && in_ready: w_en=1, w_addr=wr_ptr, w_data=in_data; wr_ptr increments modulo 16.
REQ-014 Pop SHALL occur when out_valid && out_ready.
REQ-015 ram_cnt (0..16) SHALL count words written to RAM but not yet read from it.
REQ-016 in_ready SHALL be combinational: (ram_cnt < 16) && !flush.
REQ-017 A RAM read SHALL issue when ram_cnt > 0 && !flush && (!out_valid || pop): r_en=1, r_addr=rd_ptr; rd_ptr increments modulo 16.
REQ-018 out_valid next SHALL be: 1 if a read issues; else 0 if pop; else hold.
REQ-019 ram_cnt next SHALL be ram_cnt + push - read, with simultaneous push and read leaving it unchanged.
REQ-020 level SHALL be a register equal to ram_cnt + out_valid; capacity is 17 entries (16 RAM + 1 output register).
REQ-021 Latency SHALL be: push at cycle t into an empty block gives out_valid=1 with that data at t+2.
REQ-022 Sustained throughput SHALL be one push and one pop per cycle with no bubbles once out_valid=1.
REQ-023 A read SHALL never target an address written in the same cycle, since reads require ram_cnt > 0; no RAM bypass is needed.
REQ-024 out_data SHALL remain stable while out_valid && !out_ready, because r_en=0 holds the RAM read register.
REQ-025 Ordering SHALL be strict FIFO; pointers SHALL wrap 15 -> 0 silently.
REQ-026 When flush=1, the next state SHALL be wr_ptr=rd_ptr=0, ram_cnt=0, out_valid=0, level=0.
REQ-027 Flush SHALL override push, pop and read in the same cycle: no w_en, no r_en, and out_ready is ignored.
REQ-028 in_valid while in_ready=0 SHALL have no effect; no overflow path exists.
REQ-029 out_ready while out_valid=0 SHALL have no effect; no underflow path exists.

Reset
REQ-030 rst=1 SHALL asynchronously force wr_ptr=0, rd_ptr=0, ram_cnt=0, out_valid=0, level=0.
REQ-031 After reset, in_ready SHALL be 1 once flush=0.
REQ-032 out_data SHALL be undefined after reset (the RAM is not reset) and is valid only while out_valid=1.
REQ-033 RAM contents SHALL NOT be cleared by rst or flush.
REQ-034 Reset asserted mid-transfer SHALL discard all held data; no partial state survives.

Structure
REQ-035 DW, AW, DEPTH=16 and CAPACITY=17 SHALL live in a shared package fifo_pkg.
REQ-036 fifo_ctrl SHALL instantiate exactly one sub-module: memory (16x8 RAM, registered read with enable, write-first independent ports).
REQ-037 The pointer/count logic and the output valid register SHALL be the only state in fifo_ctrl.

Verification
REQ-038 Reset then push 0xA5 at cycle 0 SHALL give out_valid=1 and out_data=0xA5 at cycle 2, with level stepping 0 -> 1.
REQ-039 Push 0x00..0x10 (17 words) with out_ready=0 SHALL give level=17, in_ready=0, and an 18th offer ignored; draining SHALL then return 0x00..0x10 in order.
REQ-040 Continuous push of 0x01..0x40 with out_ready=1 SHALL give one output per cycle in order, level constant at 2 in steady state, and pointer wrap with no data loss.
REQ-041 Fill 5 words, then flush=1 for one cycle with in_valid=1 and out_ready=1, SHALL give no write and no pop, then level=0 and out_valid=0; a subsequent push of 0x3C SHALL emerge first.
REQ-042 Holding out_ready=0 for 4 cycles with out_valid=1 SHALL keep out_data stable; random in_valid/out_ready for 2000 cycles SHALL match a reference queue model.
REQ-043 Asserting rst mid-stream at level=9 SHALL immediately give out_valid=0 and level=0, and the stream SHALL restart correctly after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing for the FIFO controller and its RAM: data width, address width, depth, capacity.
package fifo_pkg;
    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int DEPTH    = 2 ** AW;
    localparam int CAPACITY = DEPTH + 1;
endpackage

// File: rtl/fifo_ctrl_memory.sv
// Simple dual-port RAM, registered read with enable, write-first on address collision.
// One-cycle read latency; read register holds while r_en_i=0; contents are never reset.
module fifo_ctrl_memory import fifo_pkg::*; #(
    parameter int MDW = fifo_pkg::DW,
    parameter int MAW = fifo_pkg::AW
) (
    input  logic           clk_i,
    input  logic           w_en_i,
    input  logic [MAW-1:0] w_addr_i,
    input  logic [MDW-1:0] w_data_i,
    input  logic           r_en_i,
    input  logic [MAW-1:0] r_addr_i,
    output logic [MDW-1:0] r_data_o
);

    logic [MDW-1:0] mem_q [2**MAW];
    logic [MDW-1:0] r_data_q;

    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        if (r_en_i) begin
            r_data_q <= (w_en_i && (w_addr_i == r_addr_i)) ? w_data_i : mem_q[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: 16-entry RAM plus one output register (17 entries); push-to-out_valid latency 2 cycles.
// in_ready drops when the RAM holds 16 words or flush is high; out_data holds while out_ready=0.
module fifo_ctrl import fifo_pkg::*; #(
    parameter int DW = fifo_pkg::DW,
    parameter int AW = fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   level
);

    localparam logic [AW:0]   RAM_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic [AW:0]   level_q, level_d;
    logic          out_valid_q, out_valid_d;
    logic          push, pop, rd_en;

    assign in_ready = (ram_cnt_q < RAM_FULL) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready && !flush;
    // Refill the output register whenever it is empty or being drained this cycle.
    assign rd_en    = (ram_cnt_q != '0) && !flush && (!out_valid_q || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !rd_en) begin
                ram_cnt_d = ram_cnt_q + CNT_ONE;
            end else if (!push && rd_en) begin
                ram_cnt_d = ram_cnt_q - CNT_ONE;
            end
            if (rd_en) begin
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end
        level_d = ram_cnt_d + {{AW{1'b0}}, out_valid_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            level_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
        end
    end

    assign out_valid = out_valid_q;
    assign level     = level_q;

    fifo_ctrl_memory #(
        .MDW (DW),
        .MAW (AW)
    ) u_memory (
        .clk_i    (clk),
        .w_en_i   (push),
        .w_addr_i (wr_ptr_q),
        .w_data_i (in_data),
        .r_en_i   (rd_en),
        .r_addr_i (rd_ptr_q),
        .r_data_o (out_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model with per-scenario checks.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] level;

    int tests_run    = 0;
    int tests_failed = 0;
    int dut_pops     = 0;

    logic [7:0] sb[$];
    bit         mov = 1'b0;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    // Drive one cycle, check handshake outputs against the model, pop/compare the scoreboard.
    task automatic drive_cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        int ram;
        bit exp_ir, exp_pop, exp_rd;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        ram     = sb.size() - int'(mov);
        exp_ir  = (ram < 16) && !fl;
        exp_pop = mov && ordy && !fl;
        exp_rd  = (ram > 0) && !fl && (!mov || exp_pop);
        tests_run++;
        if (in_ready !== exp_ir) begin
            tests_failed++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ir, $time);
        end
        tests_run++;
        if (out_valid !== mov) begin
            tests_failed++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, mov, $time);
        end
        tests_run++;
        if (level !== 5'(sb.size())) begin
            tests_failed++;
            $display("FAIL level: got %0d expected %0d at %0t", level, sb.size(), $time);
        end
        if (out_valid === 1'b1 && ordy && !fl) dut_pops++;
        if (exp_pop) begin
            tests_run++;
            if (out_data !== sb[0]) begin
                tests_failed++;
                $display("FAIL out_data: got %h expected %h at %0t", out_data, sb[0], $time);
            end
        end
        if (fl) begin
            sb.delete();
            mov = 1'b0;
        end else begin
            if (exp_pop) void'(sb.pop_front());
            if (iv && exp_ir) sb.push_back(d);
            if (exp_rd) mov = 1'b1;
            else if (exp_pop) mov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (sb.size() != 0 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: level %0d model %0d expected 0", level, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid %b level %0d expected 0 0", out_valid, level);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_latency();
        drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        tests_run++;
        if (level !== 5'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_t1: level %0d out_valid %b expected 1 0", level, out_valid);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL latency_t2: out_valid %b data %h expected 1 a5", out_valid, out_data);
        end
        drain(3);
    endtask

    task automatic test_fill();
        logic [7:0] v;
        for (int i = 0; i <= 16; i++) begin
            v = 8'(i);
            drive_cycle(1'b1, v, 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        tests_run++;
        if (level !== 5'd17 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_full: level %0d in_ready %b expected 17 0", level, in_ready);
        end
        drain(20);
    endtask

    task automatic test_stream();
        int start_pops;
        logic [7:0] v;
        start_pops = dut_pops;
        for (int i = 1; i <= 64; i++) begin
            v = 8'(i);
            drive_cycle(1'b1, v, 1'b1, 1'b0);
            if (i >= 3) begin
                tests_run++;
                if (level !== 5'd2) begin
                    tests_failed++;
                    $display("FAIL stream_level: got %0d expected 2 at word %0d", level, i);
                end
            end
        end
        drain(4);
        tests_run++;
        if (dut_pops - start_pops != 64) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d pops expected 64", dut_pops - start_pops);
        end
    endtask

    task automatic test_flush();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) begin
            v = 8'h50 + 8'(i);
            drive_cycle(1'b1, v, 1'b0, 1'b0);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h77, 1'b1, 1'b1);
        tests_run++;
        if (level !== 5'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: level %0d out_valid %b expected 0 0", level, out_valid);
        end
        drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL flush_first: out_valid %b data %h expected 1 3c", out_valid, out_data);
        end
        drain(3);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== sb[0]) begin
                tests_failed++;
                $display("FAIL stall_hold: out_valid %b data %h expected 1 %h", out_valid, out_data, sb[0]);
            end
        end
        drain(6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain(25);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (level !== 5'd9) begin
            tests_failed++;
            $display("FAIL mid_level: got %0d expected 9", level);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: out_valid %b level %0d expected 0 0", out_valid, level);
        end
        sb.delete();
        mov = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0);
        drain(4);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_stream();
        test_flush();
        test_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
